// File: rtl/m_axi_read_pkg.sv
// ---------------------------------------------------------------------------
// m_axi_read_pkg
//   Shared constants for the AXI4 read master: burst and response codes, the
//   4KB page size and the burst-splitting FSM state encoding.
//   No ports (package).
// ---------------------------------------------------------------------------
package m_axi_read_pkg;

  // AXI burst type codes
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  // AXI response code for a clean transfer
  localparam logic [1:0] RESP_OKAY   = 2'b00;

  // Bursts may never cross this byte boundary
  localparam int unsigned PAGE_BYTES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2
  } state_e;

  // Anything other than OKAY counts as an error beat
  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/m_axi_read_burst_calc.sv
// ---------------------------------------------------------------------------
// m_axi_read_burst_calc
//   Burst sizing stage. When calc_en is high it registers the length of the
//   next AR burst (capped by remaining beats, the max burst length and, for
//   non-FIXED bursts, the distance to the next 4KB page) together with the
//   AR len field and the address the following burst will start at.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   calc_en           load the results this cycle
//   addr              current burst start address
//   beats_left        beats still to be requested (33-bit)
//   size, burst       AXI size / burst of the request
//   blen              registered beats in this burst (1..MAX_BURST_LEN)
//   arlen             registered blen-1
//   next_addr         registered start address of the following burst
// ---------------------------------------------------------------------------
module m_axi_read_burst_calc
  import m_axi_read_pkg::*;
#(
  parameter int AWIDTH        = 64,
  parameter int MAX_BURST_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              calc_en,
  input  logic [AWIDTH-1:0] addr,
  input  logic [32:0]       beats_left,
  input  logic [2:0]        size,
  input  logic [1:0]        burst,
  output logic [8:0]        blen,
  output logic [7:0]        arlen,
  output logic [AWIDTH-1:0] next_addr
);

  logic [12:0]       page_room_s;
  logic [12:0]       rem_s;
  logic [8:0]        cap_len_s;
  logic [8:0]        blen_s;
  logic [AWIDTH-1:0] next_addr_s;
  logic [8:0]        blen_r;
  logic [7:0]        arlen_r;
  logic [AWIDTH-1:0] next_addr_r;

  // Burst length: min(beats_left, max burst, beats to page end)
  always_comb begin
    page_room_s = 13'(PAGE_BYTES) - {1'b0, addr[11:0]};
    // An unaligned start near the page end can shift down to zero; still
    // issue one beat so the transfer makes progress.
    rem_s       = ((page_room_s >> size) == 13'd0) ? 13'd1 : (page_room_s >> size);
    cap_len_s   = (beats_left > 33'(MAX_BURST_LEN)) ? 9'(MAX_BURST_LEN) : beats_left[8:0];
    if ((burst != BURST_FIXED) && ({4'd0, cap_len_s} > rem_s)) begin
      blen_s = rem_s[8:0];
    end else begin
      blen_s = cap_len_s;
    end
    if (burst == BURST_INCR) begin
      next_addr_s = addr + (AWIDTH'(blen_s) << size);
    end else begin
      next_addr_s = addr;
    end
  end

  // Result registers, loaded once per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blen_r      <= 9'd0;
      arlen_r     <= 8'd0;
      next_addr_r <= '0;
    end else if (calc_en) begin
      blen_r      <= blen_s;
      arlen_r     <= 8'(blen_s - 9'd1);
      next_addr_r <= next_addr_s;
    end
  end

  assign blen      = blen_r;
  assign arlen     = arlen_r;
  assign next_addr = next_addr_r;

endmodule

// File: rtl/m_axi_read.sv
// ---------------------------------------------------------------------------
// m_axi_read
//   AXI4 read master. Accepts one core read request and splits it into AR
//   bursts of at most AXI_MAX_BURST_LEN beats that never cross a 4KB page
//   (FIXED bursts ignore the page cap). At most MAX_OUTSTANDING bursts are
//   in flight. R beats pass through a 2**RFIFO_LOGDEPTH entry FIFO to the
//   core; core_read_done pulses on dequeue of the final beat.
// Optional feature macro: M_AXI_READ_RRESP_CHECK_EN
//   defined   : core_read_resp_err is a sticky flag set by any non-OKAY
//               R beat, cleared on reset or on the next request fire.
//   undefined : core_read_resp_err is tied to 0, m_rresp is ignored.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   m_ar*                        AXI AR channel (id constant 0)
//   m_r*                         AXI R channel (rid ignored)
//   core_read_request_*          request handshake
//   core_read_addr/len/size/burst request fields (len = total beats-1)
//   core_read_data*              beat stream to the core
//   core_read_done               1-cycle pulse on final beat dequeue
//   core_read_resp_err           sticky response error flag
// ---------------------------------------------------------------------------
module m_axi_read
  import m_axi_read_pkg::*;
#(
  parameter int AXI_AWIDTH        = 64,
  parameter int AXI_DWIDTH        = 64,
  parameter int AXI_MAX_BURST_LEN = 256,
  parameter int MAX_OUTSTANDING   = 4,
  parameter int RFIFO_LOGDEPTH    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [3:0]            m_arid,
  output logic [AXI_AWIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  output logic [7:0]            m_arlen,
  output logic [2:0]            m_arsize,
  output logic [1:0]            m_arburst,
  input  logic [3:0]            m_rid,
  input  logic [AXI_DWIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  input  logic                  m_rlast,
  output logic                  m_rready,
  input  logic                  core_read_request_valid,
  output logic                  core_read_request_ready,
  input  logic [AXI_AWIDTH-1:0] core_read_addr,
  input  logic [31:0]           core_read_len,
  input  logic [2:0]            core_read_size,
  input  logic [1:0]            core_read_burst,
  output logic [AXI_DWIDTH-1:0] core_read_data,
  output logic                  core_read_data_valid,
  input  logic                  core_read_data_ready,
  output logic                  core_read_done,
  output logic                  core_read_resp_err
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = RFIFO_LOGDEPTH;
  localparam int CNT_W = RFIFO_LOGDEPTH + 1;
  localparam int DEPTH = 1 << RFIFO_LOGDEPTH;
  localparam logic [OUT_W-1:0] OUT_ONE  = OUT_W'(1);
  localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  state_e                  state_r, state_s;
  logic                    out_en_r;
  logic [AXI_AWIDTH-1:0]   addr_r;
  logic [32:0]             beats_left_r;
  logic [32:0]             total_r;
  logic [32:0]             delivered_r;
  logic [2:0]              size_r;
  logic [1:0]              burst_r;
  logic                    busy_r;
  logic [OUT_W-1:0]        outstanding_r;

  logic [8:0]              blen_s;
  logic [7:0]              arlen_s;
  logic [AXI_AWIDTH-1:0]   next_addr_s;
  logic                    calc_en_s;
  logic                    arvalid_s;
  logic                    req_fire_s;
  logic                    ar_fire_s;
  logic                    r_fire_s;
  logic                    r_last_fire_s;
  logic                    deq_fire_s;
  logic                    final_beat_s;

  logic [AXI_DWIDTH-1:0]   rfifo_mem_r [DEPTH];
  logic [PTR_W-1:0]        wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]        count_r;

  // out_en_r holds the handshake outputs low while reset is applied
  assign core_read_request_ready = out_en_r && (state_r == ST_IDLE) &&
                                   (outstanding_r == '0) && (beats_left_r == 33'd0) &&
                                   !busy_r;
  assign m_rready             = out_en_r && (count_r != CNT_FULL);
  assign core_read_data_valid = (count_r != '0);
  assign core_read_data       = rfifo_mem_r[rd_ptr_r];

  assign req_fire_s    = core_read_request_valid && core_read_request_ready;
  assign ar_fire_s     = m_arvalid && m_arready;
  assign r_fire_s      = m_rvalid && m_rready;
  assign r_last_fire_s = r_fire_s && m_rlast;
  assign deq_fire_s    = core_read_data_valid && core_read_data_ready;
  assign final_beat_s  = busy_r && (delivered_r == (total_r - 33'd1));
  assign core_read_done = deq_fire_s && final_beat_s;

  assign m_arid    = 4'd0;
  assign m_araddr  = addr_r;
  assign m_arlen   = arlen_s;
  assign m_arsize  = size_r;
  assign m_arburst = burst_r;
  assign m_arvalid = arvalid_s;

  m_axi_read_burst_calc #(
    .AWIDTH        (AXI_AWIDTH),
    .MAX_BURST_LEN (AXI_MAX_BURST_LEN)
  ) u_burst_calc (
    .clk        (clk),
    .rst        (rst),
    .calc_en    (calc_en_s),
    .addr       (addr_r),
    .beats_left (beats_left_r),
    .size       (size_r),
    .burst      (burst_r),
    .blen       (blen_s),
    .arlen      (arlen_s),
    .next_addr  (next_addr_s)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and AR-side outputs
  always_comb begin
    state_s   = state_r;
    calc_en_s = 1'b0;
    arvalid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_s = req_fire_s ? ST_CALC : ST_IDLE;
      end
      ST_CALC: begin
        calc_en_s = 1'b1;
        state_s   = ST_ISSUE;
      end
      ST_ISSUE: begin
        arvalid_s = (outstanding_r < OUT_MAX);
        if (arvalid_s && m_arready) begin
          state_s = (beats_left_r == 33'(blen_s)) ? ST_IDLE : ST_CALC;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Request latch, burst address/beat bookkeeping and delivered-beat count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_en_r     <= 1'b0;
      addr_r       <= '0;
      beats_left_r <= 33'd0;
      total_r      <= 33'd0;
      delivered_r  <= 33'd0;
      size_r       <= 3'd0;
      burst_r      <= 2'd0;
      busy_r       <= 1'b0;
    end else begin
      out_en_r <= 1'b1;
      if (req_fire_s) begin
        addr_r       <= core_read_addr;
        beats_left_r <= {1'b0, core_read_len} + 33'd1;
        total_r      <= {1'b0, core_read_len} + 33'd1;
        delivered_r  <= 33'd0;
        size_r       <= core_read_size;
        burst_r      <= core_read_burst;
        busy_r       <= 1'b1;
      end else begin
        if (ar_fire_s) begin
          addr_r       <= next_addr_s;
          beats_left_r <= beats_left_r - 33'(blen_s);
        end
        if (deq_fire_s) begin
          delivered_r <= delivered_r + 33'd1;
          if (final_beat_s) begin
            busy_r <= 1'b0;
          end
        end
      end
    end
  end

  // Bursts in flight: AR accepted but RLAST not yet seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_r <= '0;
    end else begin
      case ({ar_fire_s, r_last_fire_s})
        2'b10:   outstanding_r <= outstanding_r + OUT_ONE;
        2'b01:   outstanding_r <= (outstanding_r != '0) ? (outstanding_r - OUT_ONE) : outstanding_r;
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // R data FIFO storage (contents need no reset; count_r gates validity)
  always_ff @(posedge clk) begin
    if (r_fire_s) begin
      rfifo_mem_r[wr_ptr_r] <= m_rdata;
    end
  end

  // R data FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (r_fire_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (deq_fire_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({r_fire_s, deq_fire_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

`ifdef M_AXI_READ_RRESP_CHECK_EN
  logic resp_err_r;
  logic unused_s;

  // Sticky error flag, re-armed by each new request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_err_r <= 1'b0;
    end else if (req_fire_s) begin
      resp_err_r <= 1'b0;
    end else if (r_fire_s && resp_is_err(m_rresp)) begin
      resp_err_r <= 1'b1;
    end
  end

  assign core_read_resp_err = resp_err_r;
  assign unused_s           = ^m_rid;
`else
  logic unused_s;

  assign core_read_resp_err = 1'b0;
  assign unused_s           = ^{m_rid, m_rresp};
`endif

endmodule

// File: tb/tb_m_axi_read.sv
// ---------------------------------------------------------------------------
// tb_m_axi_read
//   Self-checking bench for m_axi_read. A behavioural AXI slave returns data
//   derived from each beat's byte address; a reference model pushes the
//   expected AR bursts and beat data for every request into scoreboard
//   queues, and a monitor pops and compares on each AR fire and each beat
//   delivered to the core.
// ---------------------------------------------------------------------------
module tb_m_axi_read;
  import m_axi_read_pkg::*;

`ifdef M_AXI_READ_RRESP_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
  } ar_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  m_arid;
  logic [63:0] m_araddr;
  logic        m_arvalid;
  logic        m_arready;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  logic [3:0]  m_rid;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rvalid;
  logic        m_rlast;
  logic        m_rready;
  logic        core_read_request_valid;
  logic        core_read_request_ready;
  logic [63:0] core_read_addr;
  logic [31:0] core_read_len;
  logic [2:0]  core_read_size;
  logic [1:0]  core_read_burst;
  logic [63:0] core_read_data;
  logic        core_read_data_valid;
  logic        core_read_data_ready;
  logic        core_read_done;
  logic        core_read_resp_err;

  always #5 clk = ~clk;

  m_axi_read dut (
    .clk                     (clk),
    .rst                     (rst),
    .m_arid                  (m_arid),
    .m_araddr                (m_araddr),
    .m_arvalid               (m_arvalid),
    .m_arready               (m_arready),
    .m_arlen                 (m_arlen),
    .m_arsize                (m_arsize),
    .m_arburst               (m_arburst),
    .m_rid                   (m_rid),
    .m_rdata                 (m_rdata),
    .m_rresp                 (m_rresp),
    .m_rvalid                (m_rvalid),
    .m_rlast                 (m_rlast),
    .m_rready                (m_rready),
    .core_read_request_valid (core_read_request_valid),
    .core_read_request_ready (core_read_request_ready),
    .core_read_addr          (core_read_addr),
    .core_read_len           (core_read_len),
    .core_read_size          (core_read_size),
    .core_read_burst         (core_read_burst),
    .core_read_data          (core_read_data),
    .core_read_data_valid    (core_read_data_valid),
    .core_read_data_ready    (core_read_data_ready),
    .core_read_done          (core_read_done),
    .core_read_resp_err      (core_read_resp_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Slave memory content: a fixed scramble of the beat's byte address
  function automatic logic [63:0] beat_data(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, a[31:0] + 32'h1234_5678};
  endfunction

  // Scoreboard
  ar_t         exp_ar_q[$];
  logic [63:0] exp_data_q[$];
  int          exp_left = 0;
  int          ar_cnt = 0;
  int          r_cnt = 0;
  int          done_cnt = 0;

  // Stimulus knobs
  bit ar_rand = 1'b0;
  bit rv_rand = 1'b0;
  bit dr_rand = 1'b0;
  bit r_hold  = 1'b0;
  bit dr_hold = 1'b0;
  bit err_next = 1'b0;

  // Behavioural AXI slave and core-side ready driver
  ar_t         sl_q[$];
  int          sl_beat = 0;
  bit          rv_fired;
  logic [63:0] sl_a;
  initial begin
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rlast = 1'b0;
    m_rresp = 2'b00; m_rid = 4'd0; core_read_data_ready = 1'b0;
    forever begin
      @(negedge clk);
      rv_fired = 1'b0;
      if (!rst) begin
        if (m_arvalid && m_arready) sl_q.push_back('{m_araddr, m_arlen, m_arsize, m_arburst});
        if (m_rvalid && m_rready) begin
          rv_fired = 1'b1;
          if (sl_beat == int'(sl_q[0].len)) begin
            void'(sl_q.pop_front());
            sl_beat = 0;
          end else begin
            sl_beat++;
          end
        end
      end
      @(posedge clk);
      #1;
      if (rst) begin
        sl_q.delete(); sl_beat = 0;
        m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
      end else begin
        m_arready = ar_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (!(m_rvalid && !rv_fired)) begin
          if (!r_hold && sl_q.size() != 0 && (!rv_rand || $urandom_range(0, 3) != 0)) begin
            sl_a = (sl_q[0].burst == BURST_INCR) ?
                   sl_q[0].addr + (64'(sl_beat) << sl_q[0].size) : sl_q[0].addr;
            m_rvalid = 1'b1;
            m_rdata  = beat_data(sl_a);
            m_rlast  = (sl_beat == int'(sl_q[0].len));
            m_rresp  = err_next ? 2'b10 : 2'b00;
            err_next = 1'b0;
          end else begin
            m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
          end
        end
        core_read_data_ready = dr_hold ? 1'b0 : (dr_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      end
    end
  end

  // Monitor: compares every AR fire and every beat delivered to the core
  ar_t e_ar;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_ar_q.delete(); exp_data_q.delete(); exp_left = 0;
      end else begin
        if (m_arvalid && m_arready) begin
          ar_cnt++;
          chk("ar_expected", 64'(exp_ar_q.size() != 0), 64'd1);
          if (exp_ar_q.size() != 0) begin
            e_ar = exp_ar_q.pop_front();
            chk("ar_addr", m_araddr, e_ar.addr);
            chk("ar_len", 64'(m_arlen), 64'(e_ar.len));
            chk("ar_size", 64'(m_arsize), 64'(e_ar.size));
            chk("ar_burst", 64'(m_arburst), 64'(e_ar.burst));
            chk("ar_id", 64'(m_arid), 64'd0);
          end
        end
        if (m_rvalid && m_rready) r_cnt++;
        if (core_read_data_valid && core_read_data_ready) begin
          chk("beat_expected", 64'(exp_data_q.size() != 0), 64'd1);
          if (exp_data_q.size() != 0) begin
            chk("beat_data", core_read_data, exp_data_q.pop_front());
            exp_left--;
          end
          if (core_read_done) done_cnt++;
          chk("done_on_last", 64'(core_read_done), 64'(exp_left == 0));
        end else if (core_read_done) begin
          chk("done_without_beat", 64'(core_read_done), 64'd0);
        end
        if (core_read_done) chk("done_vs_req_ready", 64'(core_read_request_ready), 64'd0);
      end
    end
  end

  // Reference model: expected ARs from the split rules, data per beat address
  task automatic issue_req(input logic [63:0] addr, input int len, input int size,
                           input logic [1:0] burst);
    bit got = 1'b0;
    longint unsigned left, n, room, a;
    @(posedge clk);
    #1;
    core_read_request_valid = 1'b1;
    core_read_addr = addr; core_read_len = 32'(len);
    core_read_size = 3'(size); core_read_burst = burst;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      got = core_read_request_ready;
    end
    chk("req_accept", 64'(got), 64'd1);
    if (got) begin
      left = longint'(len) + 1;
      a    = addr;
      while (left > 0) begin
        n = (left > 256) ? 256 : left;
        if (burst != BURST_FIXED) begin
          room = (4096 - (a % 4096)) >> size;
          if (n > room) n = room;
        end
        exp_ar_q.push_back('{64'(a), 8'(n - 1), 3'(size), burst});
        if (burst == BURST_INCR) a = a + (n << size);
        left = left - n;
      end
      for (int i = 0; i <= len; i++)
        exp_data_q.push_back(beat_data((burst == BURST_INCR) ? addr + (64'(i) << size) : addr));
      exp_left = len + 1;
    end
    @(posedge clk);
    #1;
    core_read_request_valid = 1'b0;
    if (got) chk("err_clear_on_req", 64'(core_read_resp_err), 64'd0);
  endtask

  task automatic wait_done(input int d0, input bit exp_err);
    for (int c = 0; c < 20000 && exp_left != 0; c++) @(negedge clk);
    chk("beats_left_at_end", 64'(exp_left), 64'd0);
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("ar_left_at_end", 64'(exp_ar_q.size()), 64'd0);
    chk("resp_err", 64'(core_read_resp_err), 64'(exp_err));
  endtask

  task automatic run(input logic [63:0] addr, input int len, input int size,
                     input logic [1:0] burst, input bit exp_err);
    int d0 = done_cnt;
    issue_req(addr, len, size, burst);
    wait_done(d0, exp_err);
  endtask

  task automatic reset_checks();
    chk("rst_arvalid", 64'(m_arvalid), 64'd0);
    chk("rst_rready", 64'(m_rready), 64'd0);
    chk("rst_dvalid", 64'(core_read_data_valid), 64'd0);
    chk("rst_done", 64'(core_read_done), 64'd0);
    chk("rst_err", 64'(core_read_resp_err), 64'd0);
    chk("rst_req_ready", 64'(core_read_request_ready), 64'd0);
    chk("rst_araddr", m_araddr, 64'd0);
    chk("rst_arlen", 64'(m_arlen), 64'd0);
  endtask

  initial begin
    int a0, r0, d0, sz;
    rst = 1'b1;
    core_read_request_valid = 1'b0; core_read_addr = '0; core_read_len = '0;
    core_read_size = 3'd0; core_read_burst = BURST_INCR;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    rst = 1'b0;

    run(64'h1000, 3, 3, BURST_INCR, 1'b0);
    run(64'h0, 299, 3, BURST_INCR, 1'b0);
    run(64'hFF0, 3, 3, BURST_INCR, 1'b0);
    run(64'h7FF8, 0, 3, BURST_INCR, 1'b0);

    // Slave withholds R: AR issue stops at the outstanding limit
    r_hold = 1'b1;
    a0 = ar_cnt; d0 = done_cnt;
    issue_req(64'h0, 2047, 3, BURST_INCR);
    repeat (40) @(negedge clk);
    chk("ar_outstanding_cap", 64'(ar_cnt - a0), 64'd4);
    chk("arvalid_at_cap", 64'(m_arvalid), 64'd0);
    r_hold = 1'b0;
    wait_done(d0, 1'b0);

    // Core stalls: FIFO fills to depth and back-pressures the slave
    dr_hold = 1'b1;
    r0 = r_cnt; d0 = done_cnt;
    issue_req(64'h2000, 31, 3, BURST_INCR);
    repeat (20) @(negedge clk);
    chk("fifo_fill_beats", 64'(r_cnt - r0), 64'd8);
    chk("rready_when_full", 64'(m_rready), 64'd0);
    chk("dvalid_when_full", 64'(core_read_data_valid), 64'd1);
    dr_hold = 1'b0;
    wait_done(d0, 1'b0);

    // Error response: sticky when enabled, cleared by the next request
    err_next = 1'b1;
    run(64'h3000, 7, 3, BURST_INCR, ERR_ON);
    run(64'h3100, 3, 3, BURST_INCR, 1'b0);

    // Reset in the middle of a transfer
    ar_rand = 1'b1; rv_rand = 1'b1; dr_rand = 1'b1;
    issue_req(64'h4000, 99, 3, BURST_INCR);
    repeat (15) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    reset_checks();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    run(64'h5000, 20, 2, BURST_INCR, 1'b0);

    // Randomized requests, random handshake timing on every channel
    for (int k = 0; k < 6; k++) begin
      sz = $urandom_range(0, 3);
      run(64'($urandom_range(0, 16383)) & ~((64'd1 << sz) - 64'd1),
          $urandom_range(0, 600), sz,
          ($urandom_range(0, 3) == 0) ? BURST_FIXED : BURST_INCR, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
